// File: rtl/occamy_pkg.sv
// -----------------------------------------------------------------------------
// occamy_pkg
//   Shared definitions for the SoC register bus.
//   Contents:
//     - Register-bus width constants (48-bit address, 32-bit data).
//     - reg_a48_d32_req_t / reg_a48_d32_rsp_t request and response structs.
//     - regbus_state_e : state encoding for register-bus slave handshakes.
// -----------------------------------------------------------------------------
package occamy_pkg;

    localparam int unsigned RegAddrWidth = 48;
    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegStrbWidth = RegDataWidth / 8;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic                    write;
        logic [RegDataWidth-1:0] wdata;
        logic [RegStrbWidth-1:0] wstrb;
        logic                    valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_a48_d32_rsp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } regbus_state_e;

endpackage : occamy_pkg

// File: rtl/regbus_sim_mem.sv
// -----------------------------------------------------------------------------
// regbus_sim_mem
//   Word-addressed register-bus memory used as a simulation target. One read
//   or write is accepted per handshake; the answer is a single registered
//   response cycle (ready = 1 for exactly one cycle), giving one access every
//   two cycles under continuous valid.
//
//   Ports:
//     clk_i  in   clock, all state updates on the rising edge
//     rst_i  in   asynchronous active-high reset; returns to IDLE, clears the
//                 response, the latched request and the whole memory
//     req_i  in   register-bus request  (addr, write, wdata, wstrb, valid)
//     rsp_o  out  register-bus response (rdata, error, ready), fully registered
//
//   Parameters:
//     AddrWidth  request address width
//     DataWidth  data width, power of two >= 8
//     NumWords   memory depth in DataWidth words
//     BaseAddr   byte address of word 0
// -----------------------------------------------------------------------------
module regbus_sim_mem
    import occamy_pkg::*;
#(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter type                  req_t     = reg_a48_d32_req_t,
    parameter type                  rsp_t     = reg_a48_d32_rsp_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  req_t req_i,
    output rsp_t rsp_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;

    // One extra bit so BaseAddr + size cannot wrap at the top of the space.
    localparam logic [AddrWidth:0] BaseExt = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0] EndExt  =
        BaseExt + ((AddrWidth+1)'(NumWords) << OffW);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    regbus_state_e                            state_q, state_d;
    logic          [IdxW-1:0]                 idx_q, idx_d;
    logic                                     write_q, write_d;
    logic          [DataWidth-1:0]            wdata_q, wdata_d;
    logic          [StrbWidth-1:0]            wstrb_q, wstrb_d;
    logic                                     err_q, err_d;
    rsp_t                                     rsp_q, rsp_d;
    logic          [NumWords-1:0][DataWidth-1:0] mem_q, mem_d;

    // ------------------------------------------------------------------
    // Request decode: range check and word index
    // ------------------------------------------------------------------
    logic [AddrWidth:0]   addr_ext;
    logic [AddrWidth-1:0] off_bytes;
    logic [IdxW-1:0]      req_idx;
    logic                 req_in_range;

    always_comb begin
        addr_ext     = {1'b0, req_i.addr};
        req_in_range = (addr_ext >= BaseExt) && (addr_ext < EndExt);
        off_bytes    = req_i.addr - BaseAddr;
        // Byte-offset bits are dropped; only meaningful when in range.
        req_idx      = IdxW'(off_bytes >> OffW);
    end

    // ------------------------------------------------------------------
    // Next-state, response and memory update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        err_d   = err_q;
        rsp_d   = '0;
        mem_d   = mem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i.valid) begin
                    state_d = ST_RESP;
                    idx_d   = req_idx;
                    write_d = req_i.write;
                    wdata_d = req_i.wdata;
                    wstrb_d = req_i.wstrb;
                    err_d   = ~req_in_range;
                    // Response is prepared now so it appears registered in
                    // the RESP cycle. Reads see every earlier write, since
                    // those committed at their own RESP edge.
                    rsp_d.ready = 1'b1;
                    rsp_d.error = ~req_in_range;
                    if (req_in_range && !req_i.write) begin
                        rsp_d.rdata = mem_q[req_idx];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Write commits on the edge that ends the RESP cycle; an
                // asynchronous reset during RESP therefore cancels it.
                if (write_q && !err_q) begin
                    for (int unsigned b = 0; b < StrbWidth; b++) begin
                        if (wstrb_q[b]) begin
                            mem_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
            mem_q   <= mem_d;
        end
    end

    assign rsp_o = rsp_q;

endmodule : regbus_sim_mem

// File: tb/tb_regbus_sim_mem.sv
// -----------------------------------------------------------------------------
// tb_regbus_sim_mem
//   Scoreboard bench for regbus_sim_mem. Each issued request pushes its
//   expected rdata/error into a queue; a monitor on the falling edge pops and
//   compares whenever rsp_o.ready is high.
// -----------------------------------------------------------------------------
module tb_regbus_sim_mem;
    import occamy_pkg::*;

    logic             clk;
    logic             rst;
    reg_a48_d32_req_t req;
    reg_a48_d32_rsp_t rsp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    string       exp_name_q[$];
    int          rdy_cyc_q[$];

    regbus_sim_mem dut (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req),
        .rsp_o (rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every response against the oldest expectation.
    always @(negedge clk) begin
        if (rsp.ready) begin
            rdy_cyc_q.push_back(cyc);
            checks++;
            if (exp_rdata_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h error=%0b, required no response",
                         rsp.rdata, rsp.error);
            end else begin
                logic [31:0] er;
                logic        ee;
                string       nm;
                er = exp_rdata_q.pop_front();
                ee = exp_err_q.pop_front();
                nm = exp_name_q.pop_front();
                if (rsp.rdata !== er || rsp.error !== ee) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h error=%0b, required rdata=%h error=%0b",
                             nm, rsp.rdata, rsp.error, er, ee);
                end
            end
        end
    end

    // Issue one request and wait for its ready cycle, then let the
    // completion edge pass. With hold=1 valid stays high for a following
    // back-to-back request.
    task automatic issue(input string nm, input logic [47:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic hold);
        int waits;
        exp_rdata_q.push_back(exp_rdata);
        exp_err_q.push_back(exp_err);
        exp_name_q.push_back(nm);
        req.addr  = addr;
        req.write = wr;
        req.wdata = wdata;
        req.wstrb = wstrb;
        req.valid = 1'b1;
        waits = 0;
        do begin
            @(posedge clk);
            #1;
            waits++;
        end while (!rsp.ready && waits < 20);
        checks++;
        if (waits != 1) begin
            errors++;
            $display("FAIL %s_latency: got ready after %0d cycles, required 1", nm, waits);
        end
        @(posedge clk);
        #1;
        if (!hold) req.valid = 1'b0;
    endtask

    initial begin
        req = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got %h, required 0", rsp);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue("rd_0_after_reset", 48'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Full write, then byte-strobe merge, then unaligned read.
        issue("wr_10_full", 48'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
        issue("rd_10_full", 48'h10, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        issue("wr_10_strb5", 48'h10, 1'b1, 32'h1122_3344, 4'h5, 32'h0, 1'b0, 1'b0);
        issue("rd_10_strb", 48'h10, 1'b0, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b0);
        issue("rd_13_unalign", 48'h13, 1'b0, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 1'b0);

        // Last word, out-of-range accesses, strobe-less write.
        issue("wr_ffc", 48'hFFC, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
        issue("rd_1000_oor", 48'h1000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        issue("wr_1000_oor", 48'h1000, 1'b1, 32'h5555_AAAA, 4'hF, 32'h0, 1'b1, 1'b0);
        issue("rd_high_oor", 48'hFFFF_0000_0000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        issue("wr_ffc_strb0", 48'hFFC, 1'b1, 32'h0123_4567, 4'h0, 32'h0, 1'b0, 1'b0);
        issue("rd_ffc_keep", 48'hFFC, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Back-to-back under continuous valid.
        @(negedge clk);
        rdy_cyc_q.delete();
        @(posedge clk);
        #1;
        issue("b2b_wr_0", 48'h0, 1'b1, 32'h1, 4'hF, 32'h0, 1'b0, 1'b1);
        issue("b2b_rd_0", 48'h0, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, 1'b1);
        issue("b2b_wr_4", 48'h4, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b1);
        issue("b2b_rd_4", 48'h4, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0, 1'b0);
        checks++;
        if (rdy_cyc_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d ready pulses, required 4", rdy_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rdy_cyc_q[i] - rdy_cyc_q[i-1] != 2) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, required 2",
                             i, rdy_cyc_q[i] - rdy_cyc_q[i-1]);
                end
            end
        end

        // Reset asserted mid-cycle during RESP of a write to 0x20.
        req.addr  = 48'h20;
        req.write = 1'b1;
        req.wdata = 32'h1234_5678;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp.ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp_ready: got ready=%0b, required 1", rsp.ready);
        end
        #1;
        rst = 1'b1;
        req.valid = 1'b0;
        #1;
        checks++;
        if (rsp !== '0) begin
            errors++;
            $display("FAIL rst_async_rsp: got %h, required 0", rsp);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue("rd_20_after_rst", 48'h20, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        issue("rd_10_zeroed", 48'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        checks++;
        if (exp_rdata_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_rdata_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regbus_sim_mem
